// File: rtl/alu_mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package alu_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 32;

    // One extra bit so the iteration count can reach WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mult_add_stage.sv
// Combinational ripple-carry adder: sum/carry of x + y, built from per-bit
// propagate/generate terms.
module mult_add_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] carry_in;
    logic             carry_out;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign prop[gi] = x[gi] ^ y[gi];
            assign gen[gi]  = x[gi] & y[gi];
        end
    endgenerate

    // The ripple is evaluated in one process so the chain is a single
    // combinational path rather than a self-referencing vector.
    always_comb begin
        logic c;
        c        = 1'b0;
        carry_in = '0;
        for (int i = 0; i < WIDTH; i++) begin
            carry_in[i] = c;
            c           = gen[i] | (prop[i] & c);
        end
        carry_out = c;
    end

    assign sum   = prop ^ carry_in;
    assign carry = carry_out;

endmodule

// File: rtl/alu_seq_multiplier.sv
// Unsigned shift-and-add multiplier: one conditional add + right shift per cycle.
// Optional EARLY_TERM_EN skips the remaining iterations once the multiplier runs out of ones.
module alu_seq_multiplier
    import alu_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   mcand_reg, mcand_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] product_reg, product_next;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH-1:0] iter_prod;
    logic [2*WIDTH-1:0] run_prod;
    logic               run_last;

    assign addend = lo_reg[0] ? mcand_reg : '0;

    mult_add_stage #(.WIDTH(WIDTH)) u_add (
        .x     (hi_reg),
        .y     (addend),
        .sum   (sum),
        .carry (carry)
    );

    // {c,s,lo} shifted right by one over 2*WIDTH+1 bits.
    assign iter_prod = {carry, sum, lo_reg[WIDTH-1:1]};

`ifdef EARLY_TERM_EN
    // Shadow of the not-yet-consumed multiplier bits; when nothing but zeros
    // remains, the leftover iterations reduce to a plain shift.
    logic [WIDTH-1:0] mrem_reg, mrem_next;
    logic             early_hit;
    logic [CNT_W-1:0] rem_shift;

    assign early_hit = (mrem_reg[WIDTH-1:1] == '0);
    assign rem_shift = LAST_CNT - cnt_reg;
    assign run_prod  = early_hit ? (iter_prod >> rem_shift) : iter_prod;
    assign run_last  = early_hit || (cnt_reg == LAST_CNT);

    always_comb begin
        mrem_next = mrem_reg;
        if (state_reg == IDLE && start) begin
            mrem_next = b;
        end else if (state_reg == RUN) begin
            mrem_next = mrem_reg >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mrem_reg <= '0;
        end else begin
            mrem_reg <= mrem_next;
        end
    end
`else
    assign run_prod = iter_prod;
    assign run_last = (cnt_reg == LAST_CNT);
`endif

    always_comb begin
        state_next   = state_reg;
        mcand_next   = mcand_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    mcand_next = a;
                    hi_next    = '0;
                    lo_next    = b;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                {hi_next, lo_next} = run_prod;
                cnt_next           = cnt_reg + CNT_W'(1);
                if (run_last) begin
                    state_next   = DONE;
                    product_next = run_prod;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign product = product_reg;

endmodule
